tf_gen_stream: RTL and testbench



---
 rtl/tf_gen_if.sv | 29 ++
 rtl/tf_gen_stream.sv | 137 +++++++++++++
 tb/tb_tf_gen_stream.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tf_gen_if.sv
// Handshake bundle between the NTT controller (master) and the twiddle-factor
// generator (slave): TF strobes and table writes in, the twiddle stream out.
interface tf_gen_if #(
    parameter int W       = 14,
    parameter int D_WIDTH = 4
);
    logic               TF_init_base;
    logic               TF_init_const;
    logic               TF_ren;
    logic               TF_wen;
    logic [D_WIDTH-1:0] it_depth_cnt;
    logic [D_WIDTH-1:0] tf_waddr;
    logic [W-1:0]       tf_wdata;
    logic [W-1:0]       tf_out;
    logic               tf_valid;
    logic               tf_group_last;

    modport master (
        output TF_init_base, TF_init_const, TF_ren, TF_wen,
        output it_depth_cnt, tf_waddr, tf_wdata,
        input  tf_out, tf_valid, tf_group_last
    );

    modport slave (
        input  TF_init_base, TF_init_const, TF_ren, TF_wen,
        input  it_depth_cnt, tf_waddr, tf_wdata,
        output tf_out, tf_valid, tf_group_last
    );
endinterface

// File: rtl/tf_gen_stream.sv
// Streams twiddle factors as a running modular product of a per-stage base
// root, restarting at group boundaries and on stage changes.
module tf_gen_stream #(
    parameter int Q         = 12289,
    parameter int W         = 14,
    parameter int STAGES    = 4,
    parameter int D_WIDTH   = 4,
    parameter int GROUP_LEN = 4
) (
    input  logic     clk,
    input  logic     rst,
    tf_gen_if.slave  bus
);
    localparam int XW = 4 * W + 2;
    localparam int GW = $clog2(GROUP_LEN);
    localparam int AW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [63:0]        MU_FULL  = (64'd1 << (2 * W)) / 64'(Q);
    localparam logic [2*W:0]       MU       = MU_FULL[2*W:0];
    localparam logic [W-1:0]       ONE_W    = W'(1);
    localparam logic [GW-1:0]      GRP_LAST = GW'(GROUP_LEN - 1);
    localparam logic [D_WIDTH-1:0] D_MAX    = D_WIDTH'(STAGES - 1);

    // Barrett reduction; the quotient estimate is low by at most 2, hence two
    // conditional subtractions.
    function automatic logic [W-1:0] mod_q(input logic [2*W-1:0] p);
        logic [XW-1:0] px;
        logic [XW-1:0] t;
        logic [XW-1:0] r;
        px = XW'(p);
        t  = (px * XW'(MU)) >> (2 * W);
        r  = px - t * XW'(Q);
        if (r >= XW'(Q)) r = r - XW'(Q);
        if (r >= XW'(Q)) r = r - XW'(Q);
        return r[W-1:0];
    endfunction

    logic [W-1:0]       base_table_reg [STAGES];
    logic [W-1:0]       acc_reg, acc_next;
    logic [W-1:0]       step_reg, step_next;
    logic [D_WIDTH-1:0] cur_depth_reg, cur_depth_next;
    logic [GW-1:0]      grp_cnt_reg, grp_cnt_next;
    logic [W-1:0]       tf_out_reg, tf_out_next;
    logic               tf_valid_reg, tf_valid_next;
    logic               tf_group_last_reg, tf_group_last_next;

    logic [D_WIDTH-1:0] d_eff;
    logic [AW-1:0]      rd_idx;
    logic [W-1:0]       base_rd;
    logic [W-1:0]       prod_mod;
    logic [W-1:0]       base_mod;

    // Base-root table; a read in the same cycle as a write sees the old entry.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_table
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    base_table_reg[gi] <= ONE_W;
                end else if (bus.TF_wen && (bus.tf_waddr == D_WIDTH'(gi))) begin
                    base_table_reg[gi] <= bus.tf_wdata;
                end
            end
        end
    endgenerate

    assign d_eff    = (bus.it_depth_cnt > D_MAX) ? D_MAX : bus.it_depth_cnt;
    assign rd_idx   = d_eff[AW-1:0];
    assign base_rd  = base_table_reg[rd_idx];
    assign prod_mod = mod_q({{W{1'b0}}, acc_reg} * {{W{1'b0}}, step_reg});
    assign base_mod = mod_q({{W{1'b0}}, base_rd});

    always_comb begin
        acc_next           = acc_reg;
        step_next          = step_reg;
        cur_depth_next     = cur_depth_reg;
        grp_cnt_next       = grp_cnt_reg;
        tf_out_next        = tf_out_reg;
        tf_valid_next      = 1'b0;
        tf_group_last_next = 1'b0;

        if (bus.TF_init_base || bus.TF_init_const) begin
            // Any init wins over a read in the same cycle; that read is lost.
            if (bus.TF_init_base) begin
                step_next      = base_rd;
                cur_depth_next = d_eff;
            end
            if (bus.TF_init_const) begin
                acc_next     = ONE_W;
                grp_cnt_next = '0;
            end
        end else if (bus.TF_ren) begin
            tf_valid_next = 1'b1;
            if (d_eff == cur_depth_reg) begin
                tf_out_next = acc_reg;
                if (grp_cnt_reg == GRP_LAST) begin
                    tf_group_last_next = 1'b1;
                    acc_next           = ONE_W;
                    grp_cnt_next       = '0;
                end else begin
                    acc_next     = prod_mod;
                    grp_cnt_next = grp_cnt_reg + GW'(1);
                end
            end else begin
                // Stage moved without an init: emit 1 and preload base^1.
                cur_depth_next = d_eff;
                step_next      = base_rd;
                tf_out_next    = ONE_W;
                acc_next       = base_mod;
                grp_cnt_next   = GW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg           <= ONE_W;
            step_reg          <= ONE_W;
            cur_depth_reg     <= '0;
            grp_cnt_reg       <= '0;
            tf_out_reg        <= '0;
            tf_valid_reg      <= 1'b0;
            tf_group_last_reg <= 1'b0;
        end else begin
            acc_reg           <= acc_next;
            step_reg          <= step_next;
            cur_depth_reg     <= cur_depth_next;
            grp_cnt_reg       <= grp_cnt_next;
            tf_out_reg        <= tf_out_next;
            tf_valid_reg      <= tf_valid_next;
            tf_group_last_reg <= tf_group_last_next;
        end
    end

    assign bus.tf_out        = tf_out_reg;
    assign bus.tf_valid      = tf_valid_reg;
    assign bus.tf_group_last = tf_group_last_reg;

endmodule

// File: tb/tb_tf_gen_stream.sv
// Bench for tf_gen_stream: a small Q=17 instance for the directed scenarios and
// a default Q=12289 instance for the random run, both scored against a model.
module tb_tf_gen_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s = 1'b1;
    logic rst_l = 1'b1;

    tf_gen_if #(.W(5),  .D_WIDTH(4)) bus_s ();
    tf_gen_if #(.W(14), .D_WIDTH(4)) bus_l ();

    tf_gen_stream #(.Q(17), .W(5), .STAGES(4), .D_WIDTH(4), .GROUP_LEN(4)) dut_s (
        .clk(clk), .rst(rst_s), .bus(bus_s)
    );
    tf_gen_stream dut_l (
        .clk(clk), .rst(rst_l), .bus(bus_l)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit sel   = 1'b0;

    // Reference model state
    longint m_q;
    longint m_tab [4];
    longint m_acc, m_step, m_out;
    int     m_dep, m_grp;
    bit     m_val, m_last;
    logic [15:0] exp_q [$];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_tab[i] = 1;
        m_acc = 1; m_step = 1; m_dep = 0; m_grp = 0;
        m_out = 0; m_val = 1'b0; m_last = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit ib, ic, ren, wen, input int d, wa, input longint wd);
        int     dd;
        longint rd;
        dd = (d >= 4) ? 3 : d;
        rd = m_tab[dd];
        m_val = 1'b0; m_last = 1'b0;
        if (ib || ic) begin
            if (ib) begin m_step = rd; m_dep = dd; end
            if (ic) begin m_acc = 1; m_grp = 0; end
        end else if (ren) begin
            m_val = 1'b1;
            if (dd == m_dep) begin
                m_out = m_acc;
                if (m_grp == 3) begin
                    m_last = 1'b1; m_acc = 1; m_grp = 0;
                end else begin
                    m_acc = (m_acc * m_step) % m_q; m_grp++;
                end
            end else begin
                m_dep = dd; m_step = rd; m_out = 1; m_acc = rd % m_q; m_grp = 1;
            end
        end
        if (wen && wa < 4) m_tab[wa] = wd;
        exp_q.push_back({m_val, m_last, 14'(m_out)});
    endtask

    task automatic drive_idle();
        bus_s.TF_init_base = 0; bus_s.TF_init_const = 0; bus_s.TF_ren = 0; bus_s.TF_wen = 0;
        bus_s.it_depth_cnt = '0; bus_s.tf_waddr = '0; bus_s.tf_wdata = '0;
        bus_l.TF_init_base = 0; bus_l.TF_init_const = 0; bus_l.TF_ren = 0; bus_l.TF_wen = 0;
        bus_l.it_depth_cnt = '0; bus_l.tf_waddr = '0; bus_l.tf_wdata = '0;
    endtask

    task automatic get_act(output logic [15:0] a);
        if (sel) a = {bus_l.tf_valid, bus_l.tf_group_last, bus_l.tf_out};
        else     a = {bus_s.tf_valid, bus_s.tf_group_last, 9'd0, bus_s.tf_out};
    endtask

    // One clock of stimulus; the model's prediction is queued, then popped and
    // compared one cycle later against the DUT.
    task automatic cycle(input bit ib, ic, ren, wen, input int d, wa, input longint wd,
                         input string tag, output logic [15:0] act);
        logic [15:0] exp_v;
        @(negedge clk);
        if (sel) begin
            bus_l.TF_init_base = ib; bus_l.TF_init_const = ic; bus_l.TF_ren = ren;
            bus_l.TF_wen = wen; bus_l.it_depth_cnt = 4'(d); bus_l.tf_waddr = 4'(wa);
            bus_l.tf_wdata = 14'(wd);
        end else begin
            bus_s.TF_init_base = ib; bus_s.TF_init_const = ic; bus_s.TF_ren = ren;
            bus_s.TF_wen = wen; bus_s.it_depth_cnt = 4'(d); bus_s.tf_waddr = 4'(wa);
            bus_s.tf_wdata = 5'(wd);
        end
        model_step(ib, ic, ren, wen, d, wa, wd);
        @(posedge clk);
        #1;
        get_act(act);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s scoreboard: got v=%0b last=%0b out=%0d, expected v=%0b last=%0b out=%0d",
                     tag, act[15], act[14], act[13:0], exp_v[15], exp_v[14], exp_v[13:0]);
        end
        $display("txn %s: ib=%0b ic=%0b ren=%0b wen=%0b d=%0d -> v=%0b last=%0b out=%0d",
                 tag, ib, ic, ren, wen, d, act[15], act[14], act[13:0]);
    endtask

    task automatic test_reset();
        logic [15:0] act;
        sel = 1'b0; m_q = 17;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus_s.tf_valid, bus_s.tf_group_last, bus_s.tf_out} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_state: got v=%0b last=%0b out=%0d, expected all 0",
                     bus_s.tf_valid, bus_s.tf_group_last, bus_s.tf_out);
        end
        @(negedge clk); rst_s = 1'b0; model_reset();
        cycle(0, 0, 1, 0, 0, 0, 0, "first_ren", act);
        n_cmp++;
        if (act !== {2'b10, 14'd1}) begin
            n_bad++;
            $display("FAIL first_ren: got v=%0b out=%0d, expected v=1 out=1", act[15], act[13:0]);
        end
        cycle(0, 0, 1, 0, 0, 0, 0, "ren", act);
        #2; rst_s = 1'b1; #1;
        n_cmp++;
        if ({bus_s.tf_valid, bus_s.tf_out} !== 6'd0) begin
            n_bad++;
            $display("FAIL async_reset: got v=%0b out=%0d, expected v=0 out=0",
                     bus_s.tf_valid, bus_s.tf_out);
        end
        @(negedge clk); drive_idle(); rst_s = 1'b0; model_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, "idle_after_rst", act);
    endtask

    task automatic test_back_to_back();
        logic [15:0] act;
        int seq [8] = '{1, 3, 9, 10, 1, 3, 9, 10};
        cycle(0, 0, 0, 1, 0, 0, 3, "wen_b0", act);
        cycle(1, 1, 0, 0, 0, 0, 0, "init", act);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, 0, 0, 0, 0, "b2b", act);
            n_cmp++;
            if (act[15] !== 1'b1 || act[13:0] !== 14'(seq[i]) || act[14] !== ((i % 4) == 3)) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got v=%0b last=%0b out=%0d, expected v=1 last=%0b out=%0d",
                         i, act[15], act[14], act[13:0], ((i % 4) == 3), seq[i]);
            end
        end
    endtask

    task automatic test_ren_in_init();
        logic [15:0] act;
        cycle(1, 1, 1, 0, 0, 0, 0, "init_ren", act);
        n_cmp++;
        if (act[15] !== 1'b0) begin
            n_bad++;
            $display("FAIL ren_in_init: got v=%0b, expected v=0", act[15]);
        end
        cycle(0, 0, 1, 0, 0, 0, 0, "after_init", act);
        n_cmp++;
        if (act !== {2'b10, 14'd1}) begin
            n_bad++;
            $display("FAIL after_init: got v=%0b out=%0d, expected v=1 out=1", act[15], act[13:0]);
        end
    endtask

    task automatic test_stage_change();
        logic [15:0] act;
        int seq [4] = '{1, 5, 8, 6};
        cycle(1, 1, 0, 0, 0, 0, 0, "init", act);
        cycle(0, 0, 1, 0, 0, 0, 0, "ren", act);
        cycle(0, 0, 1, 0, 0, 0, 0, "ren", act);
        cycle(0, 0, 0, 1, 0, 1, 5, "wen_b1", act);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 0, 1, 0, 0, "stage1", act);
            n_cmp++;
            if (act[15] !== 1'b1 || act[13:0] !== 14'(seq[i]) || act[14] !== (i == 3)) begin
                n_bad++;
                $display("FAIL stage_change[%0d]: got v=%0b last=%0b out=%0d, expected v=1 last=%0b out=%0d",
                         i, act[15], act[14], act[13:0], (i == 3), seq[i]);
            end
        end
    endtask

    task automatic test_write_collision();
        logic [15:0] act;
        int seq [6] = '{1, 3, 9, 1, 7, 15};
        cycle(1, 1, 0, 1, 0, 0, 7, "init_wen", act);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) cycle(1, 1, 0, 0, 0, 0, 0, "reinit", act);
            cycle(0, 0, 1, 0, 0, 0, 0, "coll", act);
            n_cmp++;
            if (act[13:0] !== 14'(seq[i])) begin
                n_bad++;
                $display("FAIL collision[%0d]: got out=%0d, expected out=%0d", i, act[13:0], seq[i]);
            end
        end
    endtask

    task automatic test_bounds();
        logic [15:0] act;
        int seq [5] = '{1, 4, 16, 1, 5};
        int dep [5] = '{3, 15, 3, 1, 1};
        cycle(0, 0, 0, 1, 0, 9, 2, "wen_oob", act);
        cycle(0, 0, 0, 1, 0, 3, 4, "wen_b3", act);
        cycle(1, 1, 0, 0, 12, 0, 0, "init_clamp", act);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) cycle(1, 1, 0, 0, 1, 0, 0, "init_d1", act);
            cycle(0, 0, 1, 0, dep[i], 0, 0, "bounds", act);
            n_cmp++;
            if (act[13:0] !== 14'(seq[i])) begin
                n_bad++;
                $display("FAIL bounds[%0d]: got out=%0d, expected out=%0d", i, act[13:0], seq[i]);
            end
        end
    endtask

    task automatic test_large_random();
        logic [15:0] act;
        int seq [3] = '{1, 1479, 12288};
        int d;
        sel = 1'b1; m_q = 12289;
        drive_idle();
        @(negedge clk); rst_l = 1'b0; model_reset();
        cycle(0, 0, 0, 1, 0, 0, 1479, "wen_b0", act);
        cycle(1, 1, 0, 0, 0, 0, 0, "init", act);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 0, 0, 0, 0, "q12289", act);
            n_cmp++;
            if (act[13:0] !== 14'(seq[i])) begin
                n_bad++;
                $display("FAIL q12289[%0d]: got out=%0d, expected out=%0d", i, act[13:0], seq[i]);
            end
        end
        d = 0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 15) == 0) d = $urandom_range(0, 5);
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  d, $urandom_range(0, 5), longint'($urandom_range(0, 12288)), "rand", act);
        end
    endtask

    initial begin
        m_q = 17;
        model_reset();
        drive_idle();
        test_reset();
        test_back_to_back();
        test_ren_in_init();
        test_stage_change();
        test_write_collision();
        test_bounds();
        test_large_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
